// File: rtl/mac_pkg.sv
// Shared widths, saturation bounds and parameter sanity check for the MAC pipeline.
// Pure declarations: no latency, no flow control.
package mac_pkg;

  localparam int DEF_A_WIDTH   = 21;
  localparam int DEF_B_WIDTH   = 11;
  localparam int DEF_ACC_WIDTH = 54;
  localparam int DEF_SIGNED    = 0;
  localparam int DEF_OUT_SHIFT = 0;
  localparam int DEF_OUT_WIDTH = 22;

  // Working width for bound comparisons; wide enough for any legal accumulator.
  localparam int SAT_W = 128;

  function automatic logic signed [SAT_W-1:0] sat_hi(input int w, input int sgn);
    logic signed [SAT_W-1:0] one;
    one = 1;
    return (sgn != 0) ? (one <<< (w - 1)) - one : (one <<< w) - one;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_lo(input int w, input int sgn);
    logic signed [SAT_W-1:0] one;
    one = 1;
    return (sgn != 0) ? -(one <<< (w - 1)) : '0;
  endfunction

  function automatic bit widths_ok(input int a_w, input int b_w, input int acc_w, input int out_w);
    return (acc_w >= a_w + b_w) && (acc_w < SAT_W) && (out_w < SAT_W);
  endfunction

endpackage

// File: rtl/mac_saturate.sv
// Combinational shift of the accumulator followed by clamp to the output range.
// Zero latency; no flow control.
module mac_saturate
  import mac_pkg::*;
#(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int SIGNED    = DEF_SIGNED,
  parameter int OUT_SHIFT = DEF_OUT_SHIFT,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic [ACC_WIDTH-1:0] acc,
  output logic [OUT_WIDTH-1:0] data,
  output logic                 sat
);

  localparam logic signed [SAT_W-1:0] HI = sat_hi(OUT_WIDTH, SIGNED);
  localparam logic signed [SAT_W-1:0] LO = sat_lo(OUT_WIDTH, SIGNED);

  logic signed [ACC_WIDTH-1:0] acc_s;
  logic        [ACC_WIDTH-1:0] sh_s;
  logic        [ACC_WIDTH-1:0] sh_u;
  logic        [ACC_WIDTH-1:0] sh;
  logic signed [SAT_W-1:0]     x;

  // Arithmetic and logical shifts kept separate so signedness never leaks across the mux.
  assign acc_s = acc;
  assign sh_s  = acc_s >>> OUT_SHIFT;
  assign sh_u  = acc >> OUT_SHIFT;
  assign sh    = (SIGNED != 0) ? sh_s : sh_u;

  always_comb begin
    x = '0;
    x[ACC_WIDTH-1:0] = sh;
    for (int i = ACC_WIDTH; i < SAT_W; i++) x[i] = (SIGNED != 0) && sh[ACC_WIDTH-1];
    sat  = (x > HI) || (x < LO);
    data = (x > HI) ? HI[OUT_WIDTH-1:0] :
           (x < LO) ? LO[OUT_WIDTH-1:0] : x[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/mac_pipe.sv
// Four-stage multiply-accumulate over in_first/in_last framed groups, one saturated result per group.
// Last sample to out_valid is 4 enabled edges; ce=0 freezes the whole pipe, there is no other backpressure.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int B_WIDTH   = DEF_B_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int SIGNED    = DEF_SIGNED,
  parameter int OUT_SHIFT = DEF_OUT_SHIFT,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [A_WIDTH-1:0]   in_a,
  input  logic [B_WIDTH-1:0]   in_b,
  input  logic                 in_first,
  input  logic                 in_last,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sat,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic                 err_orphan
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  if (!widths_ok(A_WIDTH, B_WIDTH, ACC_WIDTH, OUT_WIDTH)) begin : g_bad_width
    $error("mac_pipe: ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
  end

  logic                 s1_vld, s1_first, s1_last;
  logic [A_WIDTH-1:0]   s1_a;
  logic [B_WIDTH-1:0]   s1_b;
  logic                 s2_vld, s2_first, s2_last;
  logic [P_WIDTH-1:0]   s2_prod;
  logic [ACC_WIDTH-1:0] acc;
  logic                 grp_open, s3_last;
  logic [P_WIDTH-1:0]   a_ext, b_ext;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [OUT_WIDTH-1:0] sat_data;
  logic                 sat_flag;

  // Operands widened to the full product width so one '*' maps onto the DSP for both signednesses.
  always_comb begin
    a_ext = '0;
    b_ext = '0;
    a_ext[A_WIDTH-1:0] = s1_a;
    b_ext[B_WIDTH-1:0] = s1_b;
    for (int i = A_WIDTH; i < P_WIDTH; i++) a_ext[i] = (SIGNED != 0) && s1_a[A_WIDTH-1];
    for (int i = B_WIDTH; i < P_WIDTH; i++) b_ext[i] = (SIGNED != 0) && s1_b[B_WIDTH-1];
    prod_ext = '0;
    prod_ext[P_WIDTH-1:0] = s2_prod;
    for (int i = P_WIDTH; i < ACC_WIDTH; i++) prod_ext[i] = (SIGNED != 0) && s2_prod[P_WIDTH-1];
  end

  mac_saturate #(
    .ACC_WIDTH (ACC_WIDTH),
    .SIGNED    (SIGNED),
    .OUT_SHIFT (OUT_SHIFT),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_sat (
    .acc  (acc),
    .data (sat_data),
    .sat  (sat_flag)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld <= 1'b0; s1_first <= 1'b0; s1_last <= 1'b0; s1_a <= '0; s1_b <= '0;
      s2_vld <= 1'b0; s2_first <= 1'b0; s2_last <= 1'b0; s2_prod <= '0;
      acc <= '0; grp_open <= 1'b0; s3_last <= 1'b0; err_orphan <= 1'b0;
      out_valid <= 1'b0; out_data <= '0; out_sat <= 1'b0; out_acc <= '0;
    end else if (ce) begin
      s1_vld   <= in_valid;
      s1_first <= in_first;
      s1_last  <= in_last;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s2_vld   <= s1_vld;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_prod  <= a_ext * b_ext;
      // Bubbles leave the accumulator and group state alone; flags only matter with a valid sample.
      s3_last    <= s2_vld && s2_last;
      err_orphan <= s2_vld && !s2_first && !grp_open;
      if (s2_vld) begin
        acc      <= (s2_first || !grp_open) ? prod_ext : acc + prod_ext;
        grp_open <= !s2_last;
      end
      out_valid <= s3_last;
      if (s3_last) begin
        out_data <= sat_data;
        out_sat  <= sat_flag;
        out_acc  <= acc;
      end
    end
  end

endmodule
